pico_wb_master: RTL and testbench
=================================

# pico_wb_master

Parametrised bridge from the picorv32 native memory port to a pipelined Wishbone B4 master. Claims one configurable address window and runs one single-beat Wishbone cycle per CPU access. Drives `o_mem_ready` only from a real slave termination: ack, err or timeout. Sits beside the SRAM and UART slaves in the SoC top; the parent ORs `o_mem_ready` and muxes `o_mem_rdata` using `o_hit`.

## Interface
Parameters:
- `AW`, 32: address width on CPU and Wishbone sides.
- `BASE_ADDR`, 32'h8000_0000: window base; must satisfy `BASE_ADDR & ~ADDR_MASK == 0`.
- `ADDR_MASK`, 32'hFFFF_FF00: decode mask. Hit when `(addr & ADDR_MASK) == BASE_ADDR`.
- `TIMEOUT`, 255: cycles from `cyc` rise to forced termination; 0 disables the timeout.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on err or timeout.

Ports:
- Clock and reset are one clock; reset is synchronous and active-low.
- `clk`  in  1  system clock.
- `i_resetn`  in  1  synchronous active-low reset.
- `i_mem_valid`  in  1  CPU request valid.
- `i_mem_addr`  in  AW  CPU byte address.
- `i_mem_wdata`  in  32  CPU write data.
- `i_mem_wstrb`  in  4  byte strobes; 0 means read.
- `o_hit`  out  1  combinational; `i_mem_valid` and address in window.
- `o_mem_ready`  out  1  one-cycle completion pulse.
- `o_mem_rdata`  out  32  read data, valid while `o_mem_ready`.
- `o_wb_m2s_addr`  out  AW  Wishbone address.
- `o_wb_m2s_data`  out  32  Wishbone write data.
- `o_wb_m2s_we`  out  1  write enable.
- `o_wb_m2s_sel`  out  4  byte selects.
- `o_wb_m2s_cyc`  out  1  cycle.
- `o_wb_m2s_stb`  out  1  strobe.
- `i_wb_s2m_data`  in  32  slave read data.
- `i_wb_s2m_ack`  in  1  slave ack.
- `i_wb_s2m_stall`  in  1  slave stall.
- `i_wb_s2m_err`  in  1  slave error.
- `i_err_clr`  in  1  clears the sticky error status.
- `o_err`  out  1  sticky error/timeout flag.
- `o_err_addr`  out  AW  address of the first faulting access.
- `o_err_to`  out  1  1 when the latched error was a timeout, 0 when it was a slave err.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - On `o_hit`, register addr and wdata.
  - `we = |wstrb`; `sel = we ? wstrb : 4'hF`.
  - Set `cyc` and `stb` to 1, then go to REQ.
- **REQ**
  - `stb` is held until the first cycle with `!i_wb_s2m_stall`.
  - On that edge `stb` goes to 0.
  - If ack or err arrives on that same edge, go to DONE; otherwise go to WAIT.
- **WAIT**
  - Ack: capture `i_wb_s2m_data` into `o_mem_rdata`.
  - Err: capture `ERR_DATA`.
  - On either, `cyc` goes to 0 and the FSM goes to DONE.
  - Ack and err in the same cycle are treated as err.
- **DONE**
  - `o_mem_ready` is 1 for exactly one cycle, then the FSM returns to IDLE.
  - IDLE ignores `i_mem_valid` in the cycle it is re-entered only if `o_mem_ready` was high in the previous cycle. This prevents relaunching the same request, since the CPU drops valid one cycle after ready.
- **Timeout**
  - The counter runs while `cyc` is 1.
  - At count `TIMEOUT`, `cyc` and `stb` go to 0 and `o_mem_rdata = ERR_DATA`. The FSM goes to DONE and the error latch is set with `o_err_to = 1`.
- **Error latch**
  - Sets on err or timeout only if `o_err` is currently 0, so the first fault is kept.
  - `i_err_clr` clears it.
  - A new fault in the same cycle as `i_err_clr` wins.
- Accesses outside the window produce no Wishbone activity and no `o_mem_ready`.
- Write-only data is not returned: on a write ack, `o_mem_rdata` holds `i_wb_s2m_data` as sampled.

## Timing
- Reset values:
  - `cyc`, `stb`, `we`, `o_mem_ready` and `o_err` = 0.
  - `sel` = 0.
  - `addr`, `data`, `o_mem_rdata` and `o_err_addr` = 0.
  - `o_err_to` = 0.
  - FSM = IDLE; timeout counter = 0.
- Reset mid-transaction drops `cyc` and `stb` at the next edge with no `o_mem_ready`.
- Zero-wait slave (no stall, ack one cycle after accepted `stb`):
  - valid at cycle 0, `cyc`/`stb` at cycle 1, ack at cycle 2, `o_mem_ready` at cycle 3.
- Each stall cycle adds 1 cycle; each ack delay cycle adds 1 cycle.
- Outputs are registered except `o_hit`.
- Timeout counter width is `$clog2(TIMEOUT+1)`; it saturates and never wraps.

## Structure
- Package `pico_wb_pkg`: state enum `{IDLE, REQ, WAIT, DONE}` and the `SEL_READ = 4'hF` constant.
- One sub-module `wb_timeout_ctr` with ports `clk`, `i_resetn`, `i_run`, `o_expired`. The counter is held at 0 when `!i_run` or `TIMEOUT == 0`.

## Test plan
- **Zero-wait read at 0x8000_0010**, slave returns 0x0000_002A: `sel = F`, `we = 0`, `o_mem_ready` at cycle 3, `o_mem_rdata = 0x2A`.
- **Byte write** 0x0000_00AB, `wstrb = 4'b0001`, 2 stall cycles: `stb` held 3 cycles, `sel = 0001`, `data = 0xAB`, ready at cycle 5, exactly one `stb` accepted.
- **Slave err on read of 0x8000_0004**: `o_mem_rdata = DEAD_BEEF`, `o_err = 1`, `o_err_addr = 0x8000_0004`, `o_err_to = 0`. A second fault leaves the address unchanged; `i_err_clr` clears it.
- **No ack, `TIMEOUT = 8`**: `cyc` drops 8 cycles after rising, ready pulse with `DEAD_BEEF`, `o_err_to = 1`.
- **Access 0x0000_1000 (outside window)**: `o_hit = 0`, `cyc` never rises, `o_mem_ready` stays 0.
- **`i_resetn` low while in WAIT**: `cyc = stb = 0` next edge, no ready. A following read completes normally.

Source files
------------

// File: rtl/pico_wb_pkg.sv
// Shared types for the picorv32-to-Wishbone bridge.
// Holds the bridge FSM state encoding and the byte-select constant used for reads.
// No logic, no ports.
package pico_wb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } state_t;

   // Reads fetch the whole word regardless of what the CPU will use.
   localparam logic [3:0] SEL_READ = 4'hF;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Purpose: counts cycles while a Wishbone cycle is open and flags when it has run too long.
// Latency: o_expired is combinational from the count; asserts in the TIMEOUT-th cycle of i_run.
// Backpressure: none; held at 0 while !i_run or when TIMEOUT == 0 (timeout disabled).
// Ports: clk, i_resetn (sync, active-low), i_run (count enable), o_expired (terminate now).
module wb_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic i_resetn,
   input  logic i_run,
   output logic o_expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CMAX  = CW'(TIMEOUT);
   // Expiry is flagged one count early so the bus cycle is open for exactly
   // TIMEOUT cycles: the count reaches TIMEOUT on the same edge cyc drops.
   localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!i_resetn || !i_run || (TIMEOUT == 0)) begin
         count <= '0;
      end else if (count != CMAX) begin
         count <= count + CW'(1);   // saturates at TIMEOUT, never wraps
      end
   end

   assign o_expired = (TIMEOUT != 0) && i_run && (count == CLAST);

endmodule

// File: rtl/pico_wb_master.sv
// Purpose: bridges one address window of the picorv32 native memory port to a single-beat
//          pipelined Wishbone B4 master, with a sticky first-fault error latch.
// Latency: valid -> cyc/stb 1 cycle; ack -> o_mem_ready 1 cycle (zero-wait slave: 3 cycles total).
// Backpressure: stb held while i_wb_s2m_stall; CPU is held (no ready) until ack, err or timeout.
// Ports: CPU side i_mem_* / o_mem_* / o_hit; Wishbone side o_wb_m2s_* / i_wb_s2m_*;
//        error status i_err_clr / o_err / o_err_addr / o_err_to.
module pico_wb_master
   import pico_wb_pkg::*;
#(
   parameter int            AW        = 32,
   parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [AW-1:0] ADDR_MASK = 32'hFFFF_FF00,
   parameter int            TIMEOUT   = 255,
   parameter logic [31:0]   ERR_DATA  = 32'hDEAD_BEEF
) (
   input  logic          clk,
   input  logic          i_resetn,
   // picorv32 native memory port
   input  logic          i_mem_valid,
   input  logic [AW-1:0] i_mem_addr,
   input  logic [31:0]   i_mem_wdata,
   input  logic [3:0]    i_mem_wstrb,
   output logic          o_hit,
   output logic          o_mem_ready,
   output logic [31:0]   o_mem_rdata,
   // Wishbone master
   output logic [AW-1:0] o_wb_m2s_addr,
   output logic [31:0]   o_wb_m2s_data,
   output logic          o_wb_m2s_we,
   output logic [3:0]    o_wb_m2s_sel,
   output logic          o_wb_m2s_cyc,
   output logic          o_wb_m2s_stb,
   input  logic [31:0]   i_wb_s2m_data,
   input  logic          i_wb_s2m_ack,
   input  logic          i_wb_s2m_stall,
   input  logic          i_wb_s2m_err,
   // error status
   input  logic          i_err_clr,
   output logic          o_err,
   output logic [AW-1:0] o_err_addr,
   output logic          o_err_to
);

   state_t state;
   logic   ready_q;
   logic   expired;
   logic   busy;
   logic   accepted;
   logic   term_ok;
   logic   term_err;
   logic   term_to;
   logic   fault;

   assign o_hit = i_mem_valid && ((i_mem_addr & ADDR_MASK) == BASE_ADDR);

   wb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .i_resetn  (i_resetn),
      .i_run     (o_wb_m2s_cyc),
      .o_expired (expired)
   );

   // A response is only meaningful once the strobe has been taken: either
   // we are already waiting, or the slave drops stall on this very edge.
   assign busy     = (state == REQ) || (state == WAIT);
   assign accepted = (state == WAIT) || ((state == REQ) && !i_wb_s2m_stall);
   // err dominates ack when both arrive together.
   assign term_err = accepted && i_wb_s2m_err;
   assign term_ok  = accepted && i_wb_s2m_ack && !i_wb_s2m_err;
   // A real slave termination in the expiry cycle beats the timeout.
   assign term_to  = busy && expired && !term_ok && !term_err;
   assign fault    = term_err || term_to;

   always_ff @(posedge clk) begin
      if (!i_resetn) begin
         state         <= IDLE;
         ready_q       <= 1'b0;
         o_mem_ready   <= 1'b0;
         o_mem_rdata   <= '0;
         o_wb_m2s_addr <= '0;
         o_wb_m2s_data <= '0;
         o_wb_m2s_we   <= 1'b0;
         o_wb_m2s_sel  <= '0;
         o_wb_m2s_cyc  <= 1'b0;
         o_wb_m2s_stb  <= 1'b0;
         o_err         <= 1'b0;
         o_err_addr    <= '0;
         o_err_to      <= 1'b0;
      end else begin
         ready_q     <= o_mem_ready;
         o_mem_ready <= 1'b0;

         case (state)
            IDLE: begin
               // The CPU still shows the completed request for one cycle
               // after ready; ready_q stops it being launched twice.
               if (o_hit && !ready_q) begin
                  o_wb_m2s_addr <= i_mem_addr;
                  o_wb_m2s_data <= i_mem_wdata;
                  o_wb_m2s_we   <= |i_mem_wstrb;
                  o_wb_m2s_sel  <= (|i_mem_wstrb) ? i_mem_wstrb : SEL_READ;
                  o_wb_m2s_cyc  <= 1'b1;
                  o_wb_m2s_stb  <= 1'b1;
                  state         <= REQ;
               end
            end
            REQ, WAIT: begin
               if ((state == REQ) && !i_wb_s2m_stall) begin
                  o_wb_m2s_stb <= 1'b0;
                  state        <= WAIT;
               end
               if (term_ok || fault) begin
                  o_wb_m2s_cyc <= 1'b0;
                  o_wb_m2s_stb <= 1'b0;
                  o_mem_ready  <= 1'b1;
                  o_mem_rdata  <= term_ok ? i_wb_s2m_data : ERR_DATA;
                  state        <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // First fault is kept; a fault coinciding with a clear replaces it.
         if (fault && (!o_err || i_err_clr)) begin
            o_err      <= 1'b1;
            o_err_addr <= o_wb_m2s_addr;
            o_err_to   <= term_to;
         end else if (i_err_clr) begin
            o_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pico_wb_master.sv
// Self-checking bench for pico_wb_master (TIMEOUT = 8).
// Each access is predicted from the bridge's timing rules (launch, stall, ack delay, timeout)
// and compared against what the bus and CPU port actually show.
module tb_pico_wb_master;

   localparam int          TO    = 8;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam logic [31:0] MASK  = 32'hFFFF_FF00;
   localparam logic [31:0] EDATA = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        hit;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] wb_addr;
   logic [31:0] wb_wdat;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic        wb_cyc;
   logic        wb_stb;
   logic [31:0] s_data;
   logic        s_ack;
   logic        s_stall;
   logic        s_err;
   logic        err_clr;
   logic        err;
   logic [31:0] err_addr;
   logic        err_to;

   int checks   = 0;
   int failures = 0;

   // reference error-latch state
   bit          m_err      = 1'b0;
   logic [31:0] m_err_addr = '0;
   bit          m_err_to   = 1'b0;

   always #5 clk = ~clk;

   pico_wb_master #(
      .AW        (32),
      .BASE_ADDR (BASE),
      .ADDR_MASK (MASK),
      .TIMEOUT   (TO),
      .ERR_DATA  (EDATA)
   ) dut (
      .clk            (clk),
      .i_resetn       (resetn),
      .i_mem_valid    (mem_valid),
      .i_mem_addr     (mem_addr),
      .i_mem_wdata    (mem_wdata),
      .i_mem_wstrb    (mem_wstrb),
      .o_hit          (hit),
      .o_mem_ready    (mem_ready),
      .o_mem_rdata    (mem_rdata),
      .o_wb_m2s_addr  (wb_addr),
      .o_wb_m2s_data  (wb_wdat),
      .o_wb_m2s_we    (wb_we),
      .o_wb_m2s_sel   (wb_sel),
      .o_wb_m2s_cyc   (wb_cyc),
      .o_wb_m2s_stb   (wb_stb),
      .i_wb_s2m_data  (s_data),
      .i_wb_s2m_ack   (s_ack),
      .i_wb_s2m_stall (s_stall),
      .i_wb_s2m_err   (s_err),
      .i_err_clr      (err_clr),
      .o_err          (err),
      .o_err_addr     (err_addr),
      .o_err_to       (err_to)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // resp: 0 = slave never answers, 1 = ack, 2 = err, 3 = ack and err together.
   // delay: cycles from strobe acceptance to the response (0 = same cycle).
   task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int stalls, input int delay, input int resp,
                         input bit clr_req, input logic [31:0] sdata);
      bit          exp_hit = ((a & MASK) == BASE);
      bit          exp_we  = (ws != 4'h0);
      logic [3:0]  exp_sel = exp_we ? ws : 4'hF;
      int          acc     = 1 + stalls;
      int          term;
      bit          timed_out;
      bit          clr     = clr_req && exp_hit;
      logic [31:0] exp_rd;
      int          ncyc;
      bit          hit0    = 1'b0;
      int          cyc_first = -1;
      int          cyc_hi  = 0;
      int          stb_hi  = 0;
      int          acc_n   = 0;
      int          rdy_n   = 0;
      int          rdy_cyc = -1;
      logic [31:0] rd_obs  = 'x;
      logic [31:0] cap_addr = 'x;
      logic [31:0] cap_data = 'x;
      logic        cap_we   = 1'bx;
      logic [3:0]  cap_sel  = 'x;

      if (resp != 0 && acc + delay <= TO) begin
         term      = acc + delay;
         timed_out = 1'b0;
      end else begin
         term      = TO;
         timed_out = 1'b1;
      end
      if (!exp_hit) term = 0;
      exp_rd = (resp == 1 && !timed_out) ? sdata : EDATA;
      ncyc   = exp_hit ? term + 5 : 12;

      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = a;
      mem_wdata = wd;
      mem_wstrb = ws;
      s_data    = sdata;
      for (int c = 0; c < ncyc; c++) begin
         // CPU drops valid one cycle after the ready cycle
         if (c == term + 3) mem_valid = 1'b0;
         s_stall = wb_cyc && wb_stb && (c < acc);
         s_ack   = wb_cyc && (resp == 1 || resp == 3) && (c == acc + delay);
         s_err   = wb_cyc && (resp >= 2) && (c == acc + delay);
         err_clr = clr && (c == term);
         @(negedge clk);
         if (c == 0) hit0 = hit;
         if (wb_cyc) begin
            if (cyc_first < 0) cyc_first = c;
            cyc_hi++;
         end
         if (wb_cyc && wb_stb) begin
            stb_hi++;
            if (!s_stall) acc_n++;
            if (stb_hi == 1) begin
               cap_addr = wb_addr;
               cap_data = wb_wdat;
               cap_we   = wb_we;
               cap_sel  = wb_sel;
            end
         end
         if (mem_ready) begin
            rdy_n++;
            rdy_cyc = c;
            rd_obs  = mem_rdata;
         end
         @(posedge clk); #1;
      end
      mem_valid = 1'b0;
      s_stall   = 1'b0;
      s_ack     = 1'b0;
      s_err     = 1'b0;
      err_clr   = 1'b0;

      // reference error latch
      if (exp_hit && (timed_out || resp >= 2) && (!m_err || clr)) begin
         m_err      = 1'b1;
         m_err_addr = a;
         m_err_to   = timed_out;
      end else if (clr) begin
         m_err = 1'b0;
      end

      check("o_hit", hit0, exp_hit);
      if (exp_hit) begin
         check("cyc_rise_cycle", cyc_first, 1);
         check("cyc_high_cycles", cyc_hi, term);
         check("stb_high_cycles", stb_hi, (acc < term) ? acc : term);
         check("stb_accepted", acc_n, (acc <= term) ? 1 : 0);
         check("ready_pulses", rdy_n, 1);
         check("ready_cycle", rdy_cyc, term + 1);
         check("rdata", rd_obs, exp_rd);
         check("wb_addr", cap_addr, a);
         check("wb_data", cap_data, wd);
         check("wb_we", cap_we, exp_we);
         check("wb_sel", cap_sel, exp_sel);
      end else begin
         check("miss_cyc", cyc_hi, 0);
         check("miss_ready", rdy_n, 0);
      end
      check("o_err", err, m_err);
      if (m_err) begin
         check("o_err_addr", err_addr, m_err_addr);
         check("o_err_to", err_to, m_err_to);
      end
   endtask

   task automatic clear_err();
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      m_err   = 1'b0;
      @(negedge clk);
      check("err_clear", err, 1'b0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [3:0]  rs;
      int          rst_rdy;
      int          r;
      int          rresp;

      resetn    = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      s_data    = '0;
      s_ack     = 1'b0;
      s_stall   = 1'b0;
      s_err     = 1'b0;
      err_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);

      // reset state
      check("rst_cyc", wb_cyc, 1'b0);
      check("rst_stb", wb_stb, 1'b0);
      check("rst_we", wb_we, 1'b0);
      check("rst_sel", wb_sel, 4'h0);
      check("rst_addr", wb_addr, 32'h0);
      check("rst_data", wb_wdat, 32'h0);
      check("rst_ready", mem_ready, 1'b0);
      check("rst_rdata", mem_rdata, 32'h0);
      check("rst_err", err, 1'b0);
      check("rst_err_addr", err_addr, 32'h0);
      check("rst_err_to", err_to, 1'b0);

      // zero-wait read
      access(32'h8000_0010, 32'h0, 4'h0, 0, 1, 1, 1'b0, 32'h0000_002A);
      // byte write with two stall cycles
      access(32'h8000_0044, 32'h0000_00AB, 4'b0001, 2, 1, 1, 1'b0, 32'h1234_5678);
      // slave err on read, then a second fault keeps the first address
      access(32'h8000_0004, 32'h0, 4'h0, 0, 1, 2, 1'b0, 32'h5555_0000);
      access(32'h8000_0020, 32'h0, 4'h0, 1, 0, 2, 1'b0, 32'h5555_0001);
      clear_err();
      // no ack: timeout
      access(32'h8000_0008, 32'h0, 4'h0, 0, 0, 0, 1'b0, 32'h0);
      // fault in the same cycle as a clear replaces the latched one
      access(32'h8000_00C0, 32'hCAFE_0000, 4'b1100, 0, 2, 2, 1'b1, 32'h0);
      // outside the window
      access(32'h0000_1000, 32'h0, 4'h0, 0, 1, 1, 1'b0, 32'h0);
      // ack and err together count as err
      clear_err();
      access(32'h8000_0050, 32'h0, 4'h0, 0, 1, 3, 1'b0, 32'h7777_7777);
      // ack on the acceptance edge
      access(32'h8000_0060, 32'h0, 4'h0, 1, 0, 1, 1'b0, 32'h0BAD_F00D);
      // ack in the same cycle the timeout would fire
      access(32'h8000_0064, 32'h0, 4'h0, 5, 2, 1, 1'b0, 32'h0000_0F0F);
      // stalled past the timeout
      access(32'h8000_0068, 32'h0, 4'h0, 9, 0, 1, 1'b0, 32'h0);

      // reset while in WAIT
      @(posedge clk); #1;
      mem_valid = 1'b1;
      mem_addr  = 32'h8000_0030;
      mem_wstrb = 4'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("wait_cyc_before_reset", wb_cyc, 1'b1);
      @(posedge clk); #1;
      resetn    = 1'b0;
      mem_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      m_err  = 1'b0;
      @(negedge clk);
      check("reset_wait_cyc", wb_cyc, 1'b0);
      check("reset_wait_stb", wb_stb, 1'b0);
      rst_rdy = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (mem_ready) rst_rdy++;
      end
      check("reset_wait_no_ready", rst_rdy, 0);
      access(32'h8000_0034, 32'h0, 4'h0, 0, 1, 1, 1'b0, 32'hA5A5_5A5A);

      // randomized accesses
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) ra = $urandom;
         else ra = BASE | ($urandom & 32'hFF);
         rs = 4'($urandom);
         r  = $urandom_range(0, 9);
         rresp = (r < 1) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : 3;
         access(ra, $urandom, rs,
                ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 3),
                $urandom_range(0, 3), rresp, 1'($urandom_range(0, 4) == 0), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
